// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the sequencer's datapath-facing signals: the run enable, the
//   IR opcode nibble and ALU flags going in, and every bus load/drive
//   strobe plus halt/step status coming out.
//   master : the sequencer (drives strobes, halted, step)
//   slave  : the datapath / host (drives enable, opcode, flags)
interface control_sequencer_if #(
  parameter int STEP_W = 3
);
  logic              enable;
  logic [3:0]        opcode;
  logic              carry_flag;
  logic              zero_flag;

  logic              pc_out;
  logic              pc_add;
  logic              pc_in;
  logic              mar_in;
  logic              ram_in;
  logic              ram_out;
  logic              ir_in;
  logic              ir_out;
  logic              a_in;
  logic              a_out;
  logic              b_in;
  logic              alu_out;
  logic              alu_sub;
  logic              flags_in;
  logic              output_in;
  logic              halted;
  logic [STEP_W-1:0] step;

  modport master (
    input  enable, opcode, carry_flag, zero_flag,
    output pc_out, pc_add, pc_in, mar_in, ram_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, output_in,
           halted, step
  );

  modport slave (
    output enable, opcode, carry_flag, zero_flag,
    input  pc_out, pc_add, pc_in, mar_in, ram_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, output_in,
           halted, step
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcoded control unit for the 8-bit bus CPU. Steps each instruction
//   through fetch (T0-T1) and execute (T2-T4), driving every load/drive
//   strobe on the shared bus from the current step, opcode and ALU flags.
//   Ports:
//     i_clk   : system clock, all state changes on its rising edge
//     i_reset : synchronous active-high reset, aborts any instruction
//     bus     : control_sequencer_if.master (enable/opcode/flags in,
//               strobes/halted/step out)
//   Parameters:
//     FIXED_LENGTH : 0 = wrap to T0 after the opcode's last step,
//                    1 = every instruction runs T0-T4
//     STEP_W       : width of the step output
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   T0    | fetch: PC onto bus, load MAR
//   T1    | fetch: RAM onto bus, load IR, increment PC
//   T2    | execute step 1 (all opcodes; HLT sets halted here)
//   T3    | execute step 2 (LDA/ADD/SUB/STA only)
//   T4    | execute step 3 (ADD/SUB only), always wraps to T0
//   halted| r_halted=1, step frozen at T0, strobes 0 until reset
module control_sequencer #(
  parameter bit FIXED_LENGTH = 1'b0,
  parameter int STEP_W       = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  control_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  step_e r_step;
  logic  r_halted;
  step_e w_last_step;
  logic  w_active;

  // Last active step of the current opcode; undefined opcodes run as NOP.
  always_comb begin
    w_last_step = T2;
    case (bus.opcode)
      OP_LDA, OP_STA: w_last_step = T3;
      OP_ADD, OP_SUB: w_last_step = T4;
      default:        w_last_step = T2;
    endcase
  end

  assign w_active = !i_reset && bus.enable && !r_halted;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else if (bus.enable && !r_halted) begin
      if (r_step == T2 && bus.opcode == OP_HLT) begin
        // Halt parks at T0 so a later reset-free inspection sees a clean step.
        r_halted <= 1'b1;
        r_step   <= T0;
      end else if (r_step == T4 || (!FIXED_LENGTH && r_step >= w_last_step)) begin
        // ">=" also recovers if the opcode changed under a longer instruction.
        r_step <= T0;
      end else begin
        r_step <= step_e'(r_step + 3'd1);
      end
    end
  end

  assign bus.halted = r_halted;
  assign bus.step   = STEP_W'(r_step);

  // Strobe decode. Steps past an opcode's last step fall through to all-zero,
  // which is what FIXED_LENGTH=1 relies on for its padding cycles.
  always_comb begin
    bus.pc_out    = 1'b0;
    bus.pc_add    = 1'b0;
    bus.pc_in     = 1'b0;
    bus.mar_in    = 1'b0;
    bus.ram_in    = 1'b0;
    bus.ram_out   = 1'b0;
    bus.ir_in     = 1'b0;
    bus.ir_out    = 1'b0;
    bus.a_in      = 1'b0;
    bus.a_out     = 1'b0;
    bus.b_in      = 1'b0;
    bus.alu_out   = 1'b0;
    bus.alu_sub   = 1'b0;
    bus.flags_in  = 1'b0;
    bus.output_in = 1'b0;
    if (w_active) begin
      case (r_step)
        T0: begin
          bus.pc_out = 1'b1;
          bus.mar_in = 1'b1;
        end
        T1: begin
          bus.ram_out = 1'b1;
          bus.ir_in   = 1'b1;
          bus.pc_add  = 1'b1;
        end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.ir_out = 1'b1;
              bus.mar_in = 1'b1;
            end
            OP_LDI: begin
              bus.ir_out = 1'b1;
              bus.a_in   = 1'b1;
            end
            OP_JMP: begin
              bus.ir_out = 1'b1;
              bus.pc_in  = 1'b1;
            end
            OP_JC: begin
              bus.ir_out = bus.carry_flag;
              bus.pc_in  = bus.carry_flag;
            end
            OP_JZ: begin
              bus.ir_out = bus.zero_flag;
              bus.pc_in  = bus.zero_flag;
            end
            OP_OUT: begin
              bus.a_out     = 1'b1;
              bus.output_in = 1'b1;
            end
            default: ;  // NOP, HLT and undefined opcodes issue nothing
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin
              bus.ram_out = 1'b1;
              bus.a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ram_out = 1'b1;
              bus.b_in    = 1'b1;
            end
            OP_STA: begin
              bus.a_out  = 1'b1;
              bus.ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.alu_out  = 1'b1;
            bus.a_in     = 1'b1;
            bus.flags_in = 1'b1;
            bus.alu_sub  = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // OP_NOP/OP_JMP named for readability of the decode above.
  logic w_unused;
  assign w_unused = (OP_NOP == OP_JMP);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [14:0] PC_OUT   = 15'h0001;
  localparam logic [14:0] PC_ADD   = 15'h0002;
  localparam logic [14:0] PC_IN    = 15'h0004;
  localparam logic [14:0] MAR_IN   = 15'h0008;
  localparam logic [14:0] RAM_IN   = 15'h0010;
  localparam logic [14:0] RAM_OUT  = 15'h0020;
  localparam logic [14:0] IR_IN    = 15'h0040;
  localparam logic [14:0] IR_OUT   = 15'h0080;
  localparam logic [14:0] A_IN     = 15'h0100;
  localparam logic [14:0] A_OUT    = 15'h0200;
  localparam logic [14:0] B_IN     = 15'h0400;
  localparam logic [14:0] ALU_OUT  = 15'h0800;
  localparam logic [14:0] ALU_SUB  = 15'h1000;
  localparam logic [14:0] FLAGS_IN = 15'h2000;
  localparam logic [14:0] OUT_IN   = 15'h4000;

  typedef struct {
    logic [14:0] strb;
    logic [2:0]  step;
    logic        halted;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exp_t q0[$];
  exp_t q1[$];

  int   m_pos[2];
  bit   m_halt[2];

  control_sequencer_if #(.STEP_W(3)) if0();
  control_sequencer_if #(.STEP_W(3)) if1();

  control_sequencer #(.FIXED_LENGTH(1'b0), .STEP_W(3)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(if0.master));
  control_sequencer #(.FIXED_LENGTH(1'b1), .STEP_W(3)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(if1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] act0, act1;
  assign act0 = {if0.output_in, if0.flags_in, if0.alu_sub, if0.alu_out, if0.b_in,
                 if0.a_out, if0.a_in, if0.ir_out, if0.ir_in, if0.ram_out,
                 if0.ram_in, if0.mar_in, if0.pc_in, if0.pc_add, if0.pc_out};
  assign act1 = {if1.output_in, if1.flags_in, if1.alu_sub, if1.alu_out, if1.b_in,
                 if1.a_out, if1.a_in, if1.ir_out, if1.ir_in, if1.ram_out,
                 if1.ram_in, if1.mar_in, if1.pc_in, if1.pc_add, if1.pc_out};

  // Instruction length in cycles when not padded to five.
  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Microcode table: strobes for position pos of instruction op.
  function automatic logic [14:0] micro(input int pos, input logic [3:0] op,
                                        input bit c, input bit z);
    logic [14:0] s;
    s = '0;
    if (pos == 0)      s = PC_OUT | MAR_IN;
    else if (pos == 1) s = RAM_OUT | IR_IN | PC_ADD;
    else begin
      case (op)
        4'h1: if (pos == 2) s = IR_OUT | MAR_IN; else if (pos == 3) s = RAM_OUT | A_IN;
        4'h2, 4'h3: begin
          if (pos == 2) s = IR_OUT | MAR_IN;
          else if (pos == 3) s = RAM_OUT | B_IN;
          else if (pos == 4) s = ALU_OUT | A_IN | FLAGS_IN | ((op == 4'h3) ? ALU_SUB : 15'h0);
        end
        4'h4: if (pos == 2) s = IR_OUT | MAR_IN; else if (pos == 3) s = A_OUT | RAM_IN;
        4'h5: if (pos == 2) s = IR_OUT | A_IN;
        4'h6: if (pos == 2) s = IR_OUT | PC_IN;
        4'h7: if (pos == 2 && c) s = IR_OUT | PC_IN;
        4'h8: if (pos == 2 && z) s = IR_OUT | PC_IN;
        4'hE: if (pos == 2) s = A_OUT | OUT_IN;
        default: s = '0;
      endcase
    end
    return s;
  endfunction

  task automatic cycle(input bit r, input bit en, input logic [3:0] op,
                       input bit c, input bit z);
    exp_t e;
    rst = r;
    if0.enable = en; if0.opcode = op; if0.carry_flag = c; if0.zero_flag = z;
    if1.enable = en; if1.opcode = op; if1.carry_flag = c; if1.zero_flag = z;
    for (int k = 0; k < 2; k++) begin
      e.strb   = (r || !en || m_halt[k]) ? 15'h0 : micro(m_pos[k], op, c, z);
      e.step   = 3'(m_pos[k]);
      e.halted = m_halt[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int len;
      len = (k == 1) ? 5 : instr_len(op);
      if (r) begin
        m_pos[k] = 0; m_halt[k] = 1'b0;
      end else if (en && !m_halt[k]) begin
        if (m_pos[k] == 2 && op == 4'hF) begin
          m_halt[k] = 1'b1; m_pos[k] = 0;
        end else if (m_pos[k] >= len - 1) m_pos[k] = 0;
        else m_pos[k] = m_pos[k] + 1;
      end
    end
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input int n, input bit c, input bit z);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, op, c, z);
  endtask

  task automatic compare(input int d, input exp_t e, input logic [14:0] a,
                         input logic [2:0] st, input logic h,
                         input logic [4:0] outs);
    checks++;
    if (a !== e.strb) begin
      failures++;
      $display("FAIL strobes dut%0d t=%0t actual=%h required=%h", d, $time, a, e.strb);
    end
    checks++;
    if (st !== e.step) begin
      failures++;
      $display("FAIL step dut%0d t=%0t actual=%0d required=%0d", d, $time, st, e.step);
    end
    checks++;
    if (h !== e.halted) begin
      failures++;
      $display("FAIL halted dut%0d t=%0t actual=%b required=%b", d, $time, h, e.halted);
    end
    checks++;
    if ($countones(outs) > 1) begin
      failures++;
      $display("FAIL one_driver dut%0d t=%0t actual=%b required=at most one", d, $time, outs);
    end
  endtask

  // Monitor: every output sample is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e, act0, if0.step, if0.halted,
                {if0.pc_out, if0.ram_out, if0.ir_out, if0.a_out, if0.alu_out});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e, act1, if1.step, if1.halted,
                {if1.pc_out, if1.ram_out, if1.ir_out, if1.a_out, if1.alu_out});
      end
    end
  end

  initial begin
    logic [3:0] op;
    bit en;
    checks = 0; failures = 0;
    m_pos[0] = 0; m_pos[1] = 0; m_halt[0] = 1'b0; m_halt[1] = 1'b0;
    rst = 1'b1;
    if0.enable = 1'b0; if0.opcode = 4'h0; if0.carry_flag = 1'b0; if0.zero_flag = 1'b0;
    if1.enable = 1'b0; if1.opcode = 4'h0; if1.carry_flag = 1'b0; if1.zero_flag = 1'b0;
    @(posedge clk); #1;  // settle out of power-up X before scoring

    cycle(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
    run_op(4'h5, 6, 1'b0, 1'b0);           // LDI: padded run on dut1
    cycle(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    run_op(4'h2, 6, 1'b1, 1'b0);           // ADD, then fetch of next
    cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    run_op(4'h3, 6, 1'b0, 1'b1);           // SUB
    cycle(1'b1, 1'b1, 4'h7, 1'b0, 1'b0);
    run_op(4'h7, 3, 1'b0, 1'b0);           // JC not taken
    run_op(4'h7, 3, 1'b1, 1'b0);           // JC taken
    run_op(4'h8, 3, 1'b0, 1'b1);           // JZ taken
    run_op(4'hE, 3, 1'b0, 1'b0);           // OUT
    run_op(4'hB, 3, 1'b1, 1'b1);           // undefined
    // Enable dropped during T3 of LDA
    cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
    run_op(4'h1, 3, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    run_op(4'h1, 2, 1'b0, 1'b0);
    // Reset during T3 of ADD
    cycle(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    run_op(4'h2, 3, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    run_op(4'h2, 3, 1'b0, 1'b0);
    // HLT, enable toggling while halted, then reset recovers
    cycle(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    run_op(4'hF, 3, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      cycle(1'b0, i[0], 4'($urandom_range(0, 15)), 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
    run_op(4'h4, 5, 1'b0, 1'b0);

    op = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if (m_pos[0] == 0) op = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      cycle(($urandom_range(0, 63) == 0), en, op,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    #1;
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d/%0d pending required=0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU.
- Sits directly upstream of the datapath (PC, MAR, RAM, IR, A, B, ALU, output register) and drives every load and drive strobe on the shared 8-bit bus.
- Consumes the IR opcode nibble and the ALU flags.
- Steps each instruction through T-states: fetch (T0–T1), then execute (T2–T4).

Parameters:
- FIXED_LENGTH, 0, 0 = step counter returns to T0 right after each instruction's last active step; 1 = every instruction takes exactly 5 cycles (T0–T4).
- STEP_W, 3, width of the step counter output.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = sequencer advances; 0 = step held, all strobes 0
- opcode  in  4  IR[7:4]; valid from T2 onward
- carry_flag  in  1  registered ALU carry from the datapath
- zero_flag  in  1  registered ALU zero from the datapath
- pc_out, pc_add, pc_in  out  1 each  PC drive to bus / increment / load from bus
- mar_in, ram_in, ram_out  out  1 each  MAR load / RAM write at MAR / RAM drive
- ir_in, ir_out  out  1 each  IR load / IR[3:0] zero-extended onto bus
- a_in, a_out, b_in  out  1 each  A load / A drive / B load
- alu_out, alu_sub, flags_in  out  1 each  ALU drive / subtract select / flag register load
- output_in  out  1  output register load
- halted  out  1  1 once HLT has executed
- step  out  STEP_W  current T-state (0–4)

Behaviour:
- State: step register (0–4) and halted register.
- Strobes are combinational from step, opcode and flags, and are gated to 0 when any of these is true: reset=1, enable=0, halted=1.
- At most one *_out strobe is high in any cycle.
- Reset:
  - At the clock edge where reset=1: step<=0, halted<=0.
  - Reset takes priority over enable and halt, and aborts any instruction mid-flight.
  - The next instruction fetch starts at T0.
- When enable=0, step and halted hold their values.
- Fetch, all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_add.
- Execute, T2 onward. Opcode value, mnemonic, then strobes per step:
  - 0x0 NOP: T2 none. Last step T2.
  - 0x1 LDA: T2 ir_out+mar_in; T3 ram_out+a_in. Last step T3.
  - 0x2 ADD: T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in+flags_in. Last step T4.
  - 0x3 SUB: same as ADD, with alu_sub also high in T4.
  - 0x4 STA: T2 ir_out+mar_in; T3 a_out+ram_in. Last step T3.
  - 0x5 LDI: T2 ir_out+a_in. Last step T2.
  - 0x6 JMP: T2 ir_out+pc_in. Last step T2.
  - 0x7 JC: T2 ir_out+pc_in only if carry_flag=1, sampled in T2; otherwise no strobes.
  - 0x8 JZ: same as JC, using zero_flag.
  - 0xE OUT: T2 a_out+output_in.
  - 0xF HLT: T2 no strobes; halted<=1 at the end of T2.
  - 0x9–0xD: undefined; execute as NOP, no error.
- Step advance when enable=1 and halted=0:
  - FIXED_LENGTH=0: step<=0 after the opcode's last step, else step+1.
  - FIXED_LENGTH=1: step<=0 after T4, else step+1. Steps past an instruction's last step issue no strobes.
- Halt:
  - halted rises 1 cycle after HLT's T2, and step is 0 at that point.
  - Both then freeze until reset; enable has no effect.
- Cycle counts with FIXED_LENGTH=0:
  - NOP/LDI/JMP/JC/JZ/OUT: 3 cycles.
  - LDA/STA: 4 cycles.
  - ADD/SUB: 5 cycles.
- Step never exceeds 4. Wrap from T4 to T0 is unconditional.

Test Plan:
- Reset held 2 cycles, then released with enable=1: step=0; T0 has pc_out=mar_in=1; T1 has ram_out=ir_in=pc_add=1; all other strobes 0.
- opcode=0x2 (ADD), FIXED_LENGTH=0: 5-cycle sequence per table; T4 has alu_out, a_in, flags_in high and alu_sub=0; step returns to 0 on the 6th cycle. Repeat with opcode=0x3: alu_sub=1 in T4 only.
- opcode=0x7 (JC), carry_flag=0, then 0x7 with carry_flag=1: T2 has no strobes, then ir_out=pc_in=1; each instruction is 3 cycles.
- opcode=0x5 (LDI), FIXED_LENGTH=1: T2 ir_out+a_in; T3 and T4 all strobes 0; step sequence 0,1,2,3,4,0.
- opcode=0xF (HLT): halted=1 from the cycle after T2, step stuck at 0, all strobes 0 for 20 cycles with enable toggling; a reset pulse clears halted and fetch resumes at T0.
- Mid-instruction events:
  - enable dropped during T3 of LDA: step holds at 3 and strobes are 0; on re-enable, ram_out+a_in is issued once.
  - reset during T3 of ADD: step=0 next cycle, and no T4 strobes appear.
